// File: rtl/sa_row_feeder.sv
`default_nettype none
// ============================================================================
// sa_row_feeder : buffers NROWS rows and streams them into the GF(2) elimination array
// Revision      : 1.0
// ============================================================================
module sa_row_feeder #(
    parameter int DAT_W   = 4,
    parameter int NROWS   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DAT_W-1:0] wr_data,
    input  logic             go,
    output logic             sa_start,
    output logic [DAT_W-1:0] sa_data,
    input  logic             sa_finish,
    input  logic             sa_r_and,
    output logic             done,
    output logic             full_rank,
    output logic             timeout_err,
    output logic             busy
);

    localparam int FILL_W = $clog2(NROWS + 1);
    localparam int IDX_W  = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                finish_seen_q, finish_seen_d;
    logic                full_rank_q, full_rank_d;
    logic                timeout_err_q, timeout_err_d;
    logic                sa_start_q, sa_start_d;
    logic [DAT_W-1:0]    sa_data_q, sa_data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                wr_ready_q, wr_ready_d;
    logic                wr_en;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DAT_W-1:0]    rows_q [0:NROWS-1];

    assign w_wr_idx  = fill_q[IDX_W-1:0];
    assign w_idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        idx_d         = idx_q;
        wcnt_d        = wcnt_q;
        finish_seen_d = finish_seen_q;
        full_rank_d   = full_rank_q;
        timeout_err_d = timeout_err_q;
        sa_start_d    = 1'b0;
        sa_data_d     = '0;
        done_d        = 1'b0;
        wr_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    wr_en  = 1'b1;
                    fill_d = fill_q + FILL_W'(1);
                end
                // Only the pre-edge fill counts, so a same-cycle 4th write cannot launch.
                if (go && (fill_q == FILL_W'(NROWS))) begin
                    state_d       = S_STREAM;
                    idx_d         = '0;
                    finish_seen_d = 1'b0;
                    full_rank_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    sa_start_d    = 1'b1;
                    sa_data_d     = rows_q[0];
                end
            end
            S_STREAM: begin
                if (sa_finish && !finish_seen_q) begin
                    finish_seen_d = 1'b1;
                    full_rank_d   = sa_r_and;
                end
                if (idx_q == IDX_W'(NROWS - 1)) begin
                    if (finish_seen_q || sa_finish) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end
                end else begin
                    idx_d     = w_idx_nxt;
                    sa_data_d = rows_q[w_idx_nxt];
                end
            end
            S_WAIT: begin
                // A finish on the timeout cycle takes priority over the abort.
                if (sa_finish) begin
                    finish_seen_d = 1'b1;
                    full_rank_d   = sa_r_and;
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    full_rank_d   = 1'b0;
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_DONE: begin
                fill_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_STREAM) || (state_d == S_WAIT);
        wr_ready_d = (state_d == S_IDLE) && (fill_d < FILL_W'(NROWS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fill_q        <= '0;
            idx_q         <= '0;
            wcnt_q        <= '0;
            finish_seen_q <= 1'b0;
            full_rank_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sa_start_q    <= 1'b0;
            sa_data_q     <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            wr_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            idx_q         <= idx_d;
            wcnt_q        <= wcnt_d;
            finish_seen_q <= finish_seen_d;
            full_rank_q   <= full_rank_d;
            timeout_err_q <= timeout_err_d;
            sa_start_q    <= sa_start_d;
            sa_data_q     <= sa_data_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            wr_ready_q    <= wr_ready_d;
        end
    end

    // Row storage is deliberately left unreset; fill alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            rows_q[w_wr_idx] <= wr_data;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign sa_start    = sa_start_q;
    assign sa_data     = sa_data_q;
    assign done        = done_q;
    assign full_rank   = full_rank_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_row_feeder.sv
`default_nettype none
// ============================================================================
// tb_sa_row_feeder : scoreboard bench for sa_row_feeder (DAT_W=4, NROWS=4, TIMEOUT=16)
// Revision         : 1.0
// ============================================================================
module tb_sa_row_feeder;

    localparam int DAT_W   = 4;
    localparam int NROWS   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [DAT_W-1:0] wr_data;
    logic             go;
    logic             sa_start;
    logic [DAT_W-1:0] sa_data;
    logic             sa_finish;
    logic             sa_r_and;
    logic             done;
    logic             full_rank;
    logic             timeout_err;
    logic             busy;

    sa_row_feeder #(
        .DAT_W   (DAT_W),
        .NROWS   (NROWS),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .go          (go),
        .sa_start    (sa_start),
        .sa_data     (sa_data),
        .sa_finish   (sa_finish),
        .sa_r_and    (sa_r_and),
        .done        (done),
        .full_rank   (full_rank),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic           start;
        logic [DAT_W-1:0] data;
    } sexp_t;

    typedef struct {
        int   cyc;
        logic fr;
        logic te;
    } dexp_t;

    sexp_t            sq[$];
    dexp_t            dq[$];
    logic [DAT_W-1:0] exp_rows [0:NROWS-1];
    int               cyc    = 0;
    int               c0     = 0;
    int               n_chk  = 0;
    int               n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        sexp_t se;
        dexp_t de;
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            se = sq.pop_front();
            check("sa_start", {31'd0, sa_start}, {31'd0, se.start});
            check("sa_data", {28'd0, sa_data}, {28'd0, se.data});
        end else begin
            check("sa_quiet", {27'd0, sa_start, sa_data}, 32'd0);
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                de = dq.pop_front();
                check("done_cycle", cyc, de.cyc);
                check("full_rank", {31'd0, full_rank}, {31'd0, de.fr});
                check("timeout_err", {31'd0, timeout_err}, {31'd0, de.te});
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            de = dq.pop_front();
            check("done_missing", 32'd0, 32'd1);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge, pulses cleared.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        go        = 1'b0;
        wr_valid  = 1'b0;
        sa_finish = 1'b0;
        sa_r_and  = 1'b0;
    endtask

    task automatic load4(input logic [DAT_W-1:0] a, input logic [DAT_W-1:0] b,
                         input logic [DAT_W-1:0] c, input logic [DAT_W-1:0] d);
        logic [DAT_W-1:0] r [0:3];
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        for (int i = 0; i < 4; i++) begin
            wr_valid    = 1'b1;
            wr_data     = r[i];
            exp_rows[i] = r[i];
            step();
        end
    endtask

    // Drive an accepted go now; done_off==0 means no completion is expected.
    task automatic go_now(input int done_off, input logic fr, input logic te);
        sexp_t se;
        dexp_t de;
        c0 = cyc;
        go = 1'b1;
        for (int k = 0; k < NROWS; k++) begin
            se.cyc   = c0 + 1 + k;
            se.start = (k == 0);
            se.data  = exp_rows[k];
            sq.push_back(se);
        end
        if (done_off > 0) begin
            de.cyc = c0 + done_off;
            de.fr  = fr;
            de.te  = te;
            dq.push_back(de);
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; wr_valid = 1'b0; wr_data = '0;
        sa_finish = 1'b0; sa_r_and = 1'b0;
        repeat (3) step();
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_full_rank", {31'd0, full_rank}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;

        // T1: basic run, late finish
        load4(4'h8, 4'h4, 4'h2, 4'h1);
        go_now(7, 1'b1, 1'b0);
        step();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_wr_ready_busy", {31'd0, wr_ready}, 32'd0);
        while (cyc < c0 + 6) step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        check("t1_wr_ready_done", {31'd0, wr_ready}, 32'd0);
        step();
        check("t1_wr_ready_back", {31'd0, wr_ready}, 32'd1);
        check("t1_full_rank_held", {31'd0, full_rank}, 32'd1);

        // T2: overflow write dropped; finish on last row cycle
        load4(4'h3, 4'h5, 4'hA, 4'hC);
        check("t2_wr_ready_full", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b1; wr_data = 4'hF;
        step();
        go_now(5, 1'b1, 1'b0);
        step();
        while (cyc < c0 + 4) step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        step();

        // T2 partial fill: go rejected
        for (int i = 0; i < 3; i++) begin
            wr_valid    = 1'b1;
            wr_data     = 4'(6 + i);
            exp_rows[i] = 4'(6 + i);
            step();
        end
        go = 1'b1;
        step();
        step();
        check("t2_busy_partial", {31'd0, busy}, 32'd0);
        check("t2_wr_ready_partial", {31'd0, wr_ready}, 32'd1);

        // T6: go alongside the 4th write is ignored, next-cycle go launches
        wr_valid = 1'b1; wr_data = 4'hB; exp_rows[3] = 4'hB;
        go = 1'b1;
        step();
        check("t6_busy_ignored", {31'd0, busy}, 32'd0);
        go_now(5, 1'b0, 1'b0);
        step();
        sa_finish = 1'b1; sa_r_and = 1'b0;
        step();
        while (cyc < c0 + 5) step();
        step();

        // T3: timeout, sticky error, cleared by next go
        load4(4'h1, 4'h2, 4'h4, 4'h8);
        go_now(21, 1'b0, 1'b1);
        step();
        while (cyc < c0 + 21) step();
        step();
        load4(4'hF, 4'h0, 4'h5, 4'hA);
        check("t3_sticky", {31'd0, timeout_err}, 32'd1);
        go_now(5, 1'b1, 1'b0);
        step();
        check("t3_cleared", {31'd0, timeout_err}, 32'd0);
        while (cyc < c0 + 4) step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        step();

        // Finish on the same cycle as the timeout wins
        load4(4'h2, 4'h9, 4'h4, 4'h6);
        go_now(21, 1'b1, 1'b0);
        step();
        while (cyc < c0 + 20) step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        step();

        // T4: early finish, extra finish ignored
        load4(4'hE, 4'hD, 4'hB, 4'h7);
        go_now(5, 1'b0, 1'b0);
        step();
        step();
        sa_finish = 1'b1; sa_r_and = 1'b0;
        step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        while (cyc < c0 + 5) step();
        step();

        // T5: reset after row 1, then a clean reload
        load4(4'h9, 4'h6, 4'h3, 4'hC);
        go_now(0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        sq.delete();
        step();
        check("t5_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        load4(4'h1, 4'h3, 4'h7, 4'hF);
        go_now(5, 1'b1, 1'b0);
        step();
        while (cyc < c0 + 4) step();
        sa_finish = 1'b1; sa_r_and = 1'b1;
        step();
        repeat (2) step();

        check("sq_drained", sq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
